nios2_pulse_pio: RTL
====================

NIOS2_PULSE_PIO -- requirements
Module: nios2_pulse_pio

Interface
REQ-001 Parameter: WIDTH, default 8, number of output channels (1..32).
REQ-002 Parameter: CNT_W, default 16, pulse-length counter width (1..32).
REQ-003 Parameter: RESET_VALUE, default 0, WIDTH-bit reset value of the data register.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-006 Port: address  input  3  Avalon-MM slave word address.
REQ-007 Port: chipselect  input  1  slave select.
REQ-008 Port: write_n  input  1  write strobe, active-low; write = chipselect && !write_n.
REQ-009 Port: writedata  input  32  write data; bits at or above WIDTH (or CNT_W for address 2) are ignored.
REQ-010 Port: readdata  output  32  read data, combinational from address, zero wait states; unused bits 0.
REQ-011 Port: out_port  output  WIDTH  registered channel outputs, equal to the data register.
REQ-012 Port: irq  output  1  interrupt, equal to OR of (done & irqmask).

Function
REQ-013 Register map: 0 data (RW), 1 mode (RW, 1 = pulse channel), 2 pulse_len (RW, CNT_W bits), 3 done (R, W1C), 4 set (WO), 5 clear (WO), 6 toggle (WO), 7 irqmask (RW).
REQ-014 Reads of addresses 4, 5 and 6 shall return 0.
REQ-015 Writes: addr 0 shall load data; addr 4 shall OR data with writedata; addr 5 shall AND data with ~writedata; addr 6 shall XOR data with writedata.
REQ-016 Level channel (mode bit 0): the data bit holds until software changes it; its counter is idle.
REQ-017 Pulse channel, trigger: a write to addr 0, 4 or 6 that leaves the bit at 1 shall load the channel counter with L = pulse_len, or 1 if pulse_len = 0.
REQ-018 Retrigger: a trigger on a bit already high shall reload the counter, extending the pulse.
REQ-019 Countdown: each edge without a trigger on a high pulse bit with count > 1 shall decrement the count.
REQ-020 Expiry: on an edge with count = 1 and no write to that bit, the bit shall clear and done[i] shall set.
REQ-021 Timing: a trigger write at edge k shall keep out_port[i] high from edge k through edge k+L, clearing at edge k+L; the bit is high for exactly L cycles.
REQ-022 Software clear (addr 0 or 5, or a toggle to 0) during a pulse shall end the pulse at that edge, zero the counter and leave done unchanged.
REQ-023 Simultaneous expiry and software write to the same bit: the software write shall win and done shall not set.
REQ-024 Simultaneous W1C of done[i] and a new expiry on channel i: the set shall win.
REQ-025 Mode change from 1 to 0 during a pulse: the counter shall zero and the bit shall stay high with no done set; a change from 0 to 1 on a high bit shall not start a pulse until the next trigger.
REQ-026 A pulse_len write shall affect only later triggers; running counters are unaffected.
REQ-027 Channels shall operate independently; one write may trigger, clear or retrigger several channels in the same cycle.

Reset
REQ-028 While reset_n = 0 at a rising edge: data = RESET_VALUE, mode = 0, pulse_len = 0, done = 0, irqmask = 0, all counters = 0; hence irq = 0 and out_port = RESET_VALUE.
REQ-029 Reset shall abort any running pulse without setting done, and shall take priority over a simultaneous write.

Verification
REQ-030 Reset, then write addr 0 = 0xA5 and read back -> out_port = 0xA5; readdata = 0x000000A5; reads of addr 4, 5 and 6 return 0.
REQ-031 Starting from 0xA5: write addr 4 = 0x0F, addr 5 = 0x81, addr 6 = 0xFF -> out_port = 0xAF, then 0x2E, then 0xD1.
REQ-032 mode = 0x01, pulse_len = 5, irqmask = 0x01, write addr 4 = 0x01 -> bit 0 high exactly 5 cycles; done = 0x01; irq = 1; W1C addr 3 = 0x01 -> irq = 0.
REQ-033 pulse_len = 0 trigger -> 1-cycle pulse; a retrigger at cycle 3 of a 5-cycle pulse -> 8 high cycles in total; a clear at cycle 2 -> low next cycle and done stays 0.
REQ-034 Addr 5 write landing on the expiry edge -> bit 0 and done = 0; W1C landing on an expiry edge -> done stays 1; reset_n low mid-pulse -> all registers at reset values and no done.

Source files
------------

// File: rtl/nios2_pulse_pio.sv
// Avalon-MM parallel output port where each channel is either a plain level bit
// or a self-clearing pulse of programmable length with a done/interrupt flag.
module nios2_pulse_pio #(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef struct packed {
    logic ld;
    logic mode;
    logic len;
    logic w1c;
    logic set;
    logic clr;
    logic tog;
    logic mask;
  } pio_wr_t;

  pio_wr_t          wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, mode_q, mode_nxt, done_q, mask_q;
  logic [CNT_W-1:0] len_q, len_load;
  logic             unused_wd;

  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    wr = '0;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: wr.ld   = 1'b1;
        3'd1: wr.mode = 1'b1;
        3'd2: wr.len  = 1'b1;
        3'd3: wr.w1c  = 1'b1;
        3'd4: wr.set  = 1'b1;
        3'd5: wr.clr  = 1'b1;
        3'd6: wr.tog  = 1'b1;
        default: wr.mask = 1'b1;
      endcase
    end
  end

  // A zero length still gives a visible one-cycle pulse.
  assign len_load = (len_q == '0) ? CNT_W'(1) : len_q;
  assign mode_nxt = wr.mode ? wd : mode_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q <= '0;
      len_q  <= '0;
      mask_q <= '0;
    end else begin
      if (wr.mode) mode_q <= wd;
      if (wr.len)  len_q  <= writedata[CNT_W-1:0];
      if (wr.mask) mask_q <= wd;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic             d_r, dn_r, touch, nd, trig, expire;
    logic [CNT_W-1:0] cnt;

    // touch: this write addresses the bit, so it overrides any expiry this edge
    always_comb begin
      touch = wr.ld | ((wr.set | wr.clr | wr.tog) & wd[i]);
      nd    = d_r;
      if (wr.ld)       nd = wd[i];
      else if (wr.set) nd = 1'b1;
      else if (wr.clr) nd = 1'b0;
      else if (wr.tog) nd = ~d_r;
      trig   = touch & nd & mode_q[i];
      expire = ~touch & mode_nxt[i] & d_r & (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        d_r  <= RESET_VALUE[i];
        dn_r <= 1'b0;
        cnt  <= '0;
      end else begin
        dn_r <= expire | (dn_r & ~(wr.w1c & wd[i]));
        if (touch) begin
          d_r <= nd;
          cnt <= trig ? len_load : '0;
        end else if (!mode_nxt[i]) begin
          cnt <= '0;
        end else if (expire) begin
          d_r <= 1'b0;
          cnt <= '0;
        end else if (d_r && cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end

    assign data_q[i] = d_r;
    assign done_q[i] = dn_r;
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = data_q;
      3'd1:    readdata[WIDTH-1:0] = mode_q;
      3'd2:    readdata[CNT_W-1:0] = len_q;
      3'd3:    readdata[WIDTH-1:0] = done_q;
      3'd7:    readdata[WIDTH-1:0] = mask_q;
      default: readdata = '0;
    endcase
  end

  assign out_port = data_q;
  assign irq      = |(done_q & mask_q);

endmodule
